mult: RTL and testbench

MULT -- requirements
Module: mult

---
 rtl/mult.sv | 88 ++++++++
 tb/tb_mult.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mult.sv
// mult: sequential signed 32x32 -> 64-bit multiplier, radix-2 Booth, one iteration per cycle.
//
// Ports:
//   clk       rising-edge clock for all state
//   reset     synchronous active-high reset
//   srcA      signed multiplicand, sampled on an init edge (multCtrl=1)
//   srcB      signed multiplier, sampled on an init edge
//   multCtrl  init strobe; loads operands and (re)starts an operation from any state
//   multDone  one-cycle pulse when hi/lo hold a freshly completed product
//   hi        upper 32 bits of the signed product (registered, held until next init/reset)
//   lo        lower 32 bits of the signed product (registered, held until next init/reset)
//
// An init edge clears hi/lo; the result is written 32 edges later.

module mult (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        multCtrl,
    output logic        multDone,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e      state_q;
    logic [32:0] acc_q;     // accumulator A, one guard bit so A +/- M never overflows
    logic [32:0] m_q;       // sign-extended multiplicand
    logic [31:0] q_q;       // multiplier, shifts out as product low half shifts in
    logic        qm1_q;     // Booth look-back bit
    logic [5:0]  cnt_q;     // iterations completed

    logic [32:0] acc_sum;
    logic [32:0] acc_shift;
    logic [31:0] q_shift;
    logic        qm1_shift;

    // Booth recode on {Q[0], Qm1}, then arithmetic shift of {A, Q, Qm1} right by one.
    always_comb begin
        acc_sum = acc_q;
        case ({q_q[0], qm1_q})
            2'b01:   acc_sum = acc_q + m_q;
            2'b10:   acc_sum = acc_q - m_q;
            default: acc_sum = acc_q;
        endcase
        acc_shift = {acc_sum[32], acc_sum[32:1]};
        q_shift   = {acc_sum[0], q_q[31:1]};
        qm1_shift = q_q[0];
    end

    always_ff @(posedge clk) begin
        multDone <= 1'b0;
        if (reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (multCtrl) begin
            // Init wins over completion: an op finishing on this edge is discarded.
            state_q <= StRun;
            acc_q   <= '0;
            m_q     <= {srcA[31], srcA};
            q_q     <= srcB;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (state_q == StRun) begin
            acc_q <= acc_shift;
            q_q   <= q_shift;
            qm1_q <= qm1_shift;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
                hi       <= acc_shift[31:0];
                lo       <= q_shift;
                multDone <= 1'b1;
                state_q  <= StIdle;
            end
        end
    end

endmodule

// File: tb/tb_mult.sv
// tb_mult: self-checking bench for mult.
// Directed product table with hand-computed results, plus sequences for abort, reset
// mid-operation, held init, completion-edge restart, and a short random regression
// against a 64-bit signed reference product.

module tb_mult;

    logic        clk;
    logic        reset;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        multCtrl;
    logic        multDone;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mult dut (
        .clk      (clk),
        .reset    (reset),
        .srcA     (srcA),
        .srcB     (srcB),
        .multCtrl (multCtrl),
        .multDone (multDone),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h required 0x%h", nm, act, exp);
        end
    endtask

    // Advance to #1 after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle init; returns #1 after the init edge with multCtrl low.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        srcA     = a;
        srcB     = b;
        multCtrl = 1'b1;
        step();
        multCtrl = 1'b0;
    endtask

    // Called #1 after the last init edge. Expects multDone exactly at edge 32, correct
    // hi/lo, then multDone low and hi/lo held afterwards.
    task automatic expect_result(input string nm, input logic [31:0] exp_hi,
                                 input logic [31:0] exp_lo, input bit scramble);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (scramble) begin
                srcA = $urandom;
                srcB = $urandom;
            end
            if (multDone) begin
                n = i;
                break;
            end
        end
        chk({nm, " latency"}, 64'(n), 64'd32);
        chk({nm, " product"}, {hi, lo}, {exp_hi, exp_lo});
        step();
        chk({nm, " done drop"}, 64'(multDone), 64'd0);
        chk({nm, " hold"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int pulses;
        logic [63:0] ref_p;

        vecs[0]  = '{32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[2]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[4]  = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
        vecs[5]  = '{32'd2,        32'd3,        32'h00000000, 32'h00000006};
        vecs[6]  = '{32'hFFFFFFFE, 32'd4,        32'hFFFFFFFF, 32'hFFFFFFF8};
        vecs[7]  = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[8]  = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[9]  = '{32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000};
        vecs[10] = '{32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000};
        vecs[11] = '{32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

        reset    = 1'b1;
        multCtrl = 1'b1;
        srcA     = 32'h5;
        srcB     = 32'h6;
        step();
        step();
        chk("reset outputs", {31'd0, multDone, hi, lo}, 64'd0);
        reset    = 1'b0;
        multCtrl = 1'b0;
        pulses   = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (multDone) pulses++;
        end
        chk("idle after reset", {32'(pulses), hi}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            start(vecs[i].a, vecs[i].b);
            expect_result($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, 1'b0);
        end

        // Idle hold over several cycles.
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (multDone) pulses++;
        end
        chk("idle hold", {hi, lo}, {vecs[11].hi, vecs[11].lo});
        chk("idle no pulse", 64'(pulses), 64'd0);

        // Abort at iteration 10 with new operands.
        start(32'd5, 32'd6);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (multDone) pulses++;
        end
        chk("abort no early pulse", 64'(pulses), 64'd0);
        start(32'hFFFFFFFE, 32'd4);
        expect_result("abort restart", 32'hFFFFFFFF, 32'hFFFFFFF8, 1'b0);

        // Reset mid-operation.
        start(32'd100, 32'd100);
        for (int i = 0; i < 15; i++) step();
        reset = 1'b1;
        step();
        chk("midreset outputs", {31'd0, multDone, hi, lo}, 64'd0);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (multDone) pulses++;
        end
        chk("midreset no pulse", 64'(pulses), 64'd0);

        // Held init: last-sampled operands win; inputs scrambled during run.
        srcA     = 32'd3;
        srcB     = 32'd4;
        multCtrl = 1'b1;
        step();
        step();
        srcA = 32'd9;
        srcB = 32'd9;
        step();
        multCtrl = 1'b0;
        expect_result("held init", 32'd0, 32'd81, 1'b1);

        // Init on the completion edge takes priority.
        start(32'd7, 32'hFFFFFFFD);
        for (int i = 0; i < 31; i++) step();
        srcA     = 32'h00010000;
        srcB     = 32'h00010000;
        multCtrl = 1'b1;
        step();
        multCtrl = 1'b0;
        chk("priority no done", {31'd0, multDone, hi, lo}, 64'd0);
        expect_result("priority restart", 32'd1, 32'd0, 1'b0);

        // Random regression against a 64-bit signed reference.
        for (int i = 0; i < 100; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 10 == 0) ra = 32'h80000000;
            if (i % 10 == 5) rb = 32'hFFFFFFFF;
            ref_p = 64'(longint'($signed(ra)) * longint'($signed(rb)));
            start(ra, rb);
            expect_result($sformatf("rand%0d", i), ref_p[63:32], ref_p[31:0], 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
